// File: rtl/hack_pkg.sv
// Shared Hack-platform definitions: native word width and the serializer FSM states.
package hack_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial word transmitter with valid/ready on both sides.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module word_serializer
    import hack_pkg::*;
#(
    parameter int WIDTH     = HACK_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    ser_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_shift;
    logic             shreg_en;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             in_hs;
    logic             out_hs;
    logic             fill_bit;

    assign in_hs   = in_valid & in_ready_q;
    assign out_hs  = out_valid_q & out_ready;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef WORD_SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (in_hs) begin
            parity_q <= ^in;
        end
    end

    // Every shift fills with parity; the first fill reaches the output port after WIDTH shifts.
    assign fill_bit = parity_q;
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        if (MSB_FIRST) begin
            shreg_shift = (shreg_q << 1) | WIDTH'(fill_bit);
        end else begin
            shreg_shift = (shreg_q >> 1) | (WIDTH'(fill_bit) << (WIDTH - 1));
        end
        shreg_en = in_hs | out_hs;
        shreg_d  = in_hs ? in : shreg_shift;
    end

    // Load-enabled word register; the serial output is taken straight from its head bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (shreg_en) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            shreg_q <= shreg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        state_q     <= SHIFT;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (LAST_IDX == '0);
                    end
                end
                SHIFT: begin
                    if (out_hs) begin
                        if (out_last_q) begin
                            // Returning here costs one bubble before the next word is taken.
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_inc;
                            out_last_q <= (cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule
